ysyx_22041461_regfile_sb: RTL and testbench
===========================================

# ysyx_22041461_regfile_sb

Parametrised integer register file with scoreboard for the pipelined core. Two combinational read ports with same-cycle write-back bypass, one write-back port, and per-register pending-write counters. Decode uses the busy outputs to stall on RAW hazards. Sits between decode (reads, issue) and write-back (retire), replacing the single-cycle register file.

## Interface
Parameters:
- XLEN, 64, data width of each register
- NREG, 32, number of architectural registers (power of two; AW = log2(NREG))
- CNTW, 2, width of each pending-write counter (max outstanding writes per register = 2^CNTW-1)

Ports:
- clk  input  1  single clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- rs1, rs2  input  AW  read addresses
- rs1_data, rs2_data  output  XLEN  read data (bypassed)
- rs1_busy, rs2_busy  output  1  register has an unresolved pending write
- iss_valid  input  1  decode requests to reserve destination iss_rd
- iss_rd  input  AW  destination being reserved
- iss_ready  output  1  reservation can be accepted this cycle
- wen  input  1  write-back strobe (retires one pending write)
- waddr  input  AW  write-back address
- wdata  input  XLEN  write-back data
- flush  input  1  discard all pending reservations (pipeline squash)

## Operation
- Storage: NREG x XLEN registers + NREG x CNTW counters cnt[i]. Register 0 reads 0 always, never written, cnt[0] always 0.
- Read: rsN_data = 0 if rsN==0; else wdata if wen && waddr==rsN; else reg[rsN].
- Busy: rsN_busy = (cnt[rsN] != 0) && !(wen && waddr==rsN && cnt[rsN]==1). rsN==0 -> busy 0.
- Issue handshake: fire_iss = iss_valid && iss_ready. iss_ready = 0 only when iss_rd!=0 and cnt[iss_rd] == 2^CNTW-1 and not (wen && waddr==iss_rd). iss_rd==0 -> ready 1, no state change.
- iss_ready must not depend on iss_valid; iss_valid may depend on iss_ready only combinationally-free (decode holds request until accepted).
- Write: on wen && waddr!=0, reg[waddr] <= wdata at posedge. Write happens regardless of cnt and flush.
- Counter update per register i (i!=0), priority top-down:
  - flush: cnt[i] <= 0 (concurrent issue ignored; concurrent wen still writes data).
  - inc (fire_iss && iss_rd==i) and dec (wen && waddr==i && cnt[i]!=0): cnt unchanged.
  - inc only: cnt+1. dec only: cnt-1.
  - wen to register with cnt==0 (late write after flush, or untracked write): data written, cnt stays 0, no underflow.
- Arithmetic: counters unsigned CNTW bits, never wrap (guarded by iss_ready and the cnt!=0 check).

## Timing
- Reset (rst=1 at posedge): all reg = 0, all cnt = 0. After reset: rs*_data = 0, rs*_busy = 0, iss_ready = 1.
- rst dominates wen, iss_valid, flush in the same cycle.
- Read latency 0 (combinational, including bypass); write visible in reg at cycle N+1, via bypass in cycle N.
- Reservation at posedge N makes busy visible from cycle N+1; a same-cycle issue does not affect busy for that cycle's reads.
- Retire in cycle N clears busy combinationally in N when it is the last outstanding write.
- flush at posedge N: busy = 0 for all registers from N+1.

## Test plan
- Reset: write x5=0x1234 then assert rst one cycle -> rs1=5 reads 0, busy 0, iss_ready 1.
- x0 guard: wen waddr=0 wdata=0xFFFF_FFFF_FFFF_FFFF, iss_rd=0 -> rs1=0 reads 0, rs1_busy 0, iss_ready 1, no counter change.
- Bypass and busy: issue rd=7 (cycle 0); cycle 1 rs2=7 busy 1; cycle 3 wen waddr=7 wdata=0xDEAD -> same cycle rs2_data=0xDEAD, rs2_busy 0; cycle 4 reads 0xDEAD from array.
- Saturation (CNTW=2): issue rd=3 three times -> cnt=3, iss_ready 0 for rd=3 with no wen; same cycle wen waddr=3 -> iss_ready 1, issue+retire leaves cnt=3; three more retires -> busy 0.
- Flush: reserve x4, x9; assert flush with iss_valid rd=4 and wen waddr=9 wdata=0x55 -> next cycle both busy 0, x9 reads 0x55; later wen waddr=4 -> data written, cnt stays 0.
- Randomised issue/retire/flush against a reference model: busy and data match every cycle, no counter under/overflow.

Source files
------------

// File: rtl/ysyx_22041461_regfile_sb.sv
// ysyx_22041461_regfile_sb
// Integer register file with a per-register pending-write scoreboard.
// Two combinational read ports bypass the write-back port in the same cycle.
// Each register keeps a small counter of outstanding writes, which decode uses to stall on RAW hazards.
// Register 0 is hard-wired to zero and is never tracked.
module ysyx_22041461_regfile_sb #(
   parameter  int XLEN = 64,
   parameter  int NREG = 32,
   parameter  int CNTW = 2,
   localparam int AW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic            rs1_busy,
   output logic            rs2_busy,
   input  logic            iss_valid,
   input  logic [AW-1:0]   iss_rd,
   output logic            iss_ready,
   input  logic            wen,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic            flush
);

   localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
   localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};
   localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};
   localparam logic [AW-1:0]   ADDR_X0  = {AW{1'b0}};

   logic [XLEN-1:0] regs_r    [NREG];
   logic [CNTW-1:0] cnt_r     [NREG];
   logic [CNTW-1:0] cnt_nxt_s [NREG];
   logic [NREG-1:0] inc_s;
   logic [NREG-1:0] dec_s;
   logic            fire_iss_s;

   // Read port 1: x0 reads zero, otherwise a same-cycle write-back wins over the stored value.
   always_comb begin
      rs1_data = {XLEN{1'b0}};
      if (rs1 == ADDR_X0) begin
         rs1_data = {XLEN{1'b0}};
      end else if (wen && (waddr == rs1)) begin
         rs1_data = wdata;
      end else begin
         rs1_data = regs_r[rs1];
      end
   end

   // Read port 2: same bypass rule as port 1.
   always_comb begin
      rs2_data = {XLEN{1'b0}};
      if (rs2 == ADDR_X0) begin
         rs2_data = {XLEN{1'b0}};
      end else if (wen && (waddr == rs2)) begin
         rs2_data = wdata;
      end else begin
         rs2_data = regs_r[rs2];
      end
   end

   // Busy for port 1: pending writes exist, unless this cycle retires the last one.
   always_comb begin
      rs1_busy = 1'b0;
      if (rs1 == ADDR_X0) begin
         rs1_busy = 1'b0;
      end else if (cnt_r[rs1] == CNT_ZERO) begin
         rs1_busy = 1'b0;
      end else if (wen && (waddr == rs1) && (cnt_r[rs1] == CNT_ONE)) begin
         rs1_busy = 1'b0;
      end else begin
         rs1_busy = 1'b1;
      end
   end

   // Busy for port 2: same rule as port 1.
   always_comb begin
      rs2_busy = 1'b0;
      if (rs2 == ADDR_X0) begin
         rs2_busy = 1'b0;
      end else if (cnt_r[rs2] == CNT_ZERO) begin
         rs2_busy = 1'b0;
      end else if (wen && (waddr == rs2) && (cnt_r[rs2] == CNT_ONE)) begin
         rs2_busy = 1'b0;
      end else begin
         rs2_busy = 1'b1;
      end
   end

   // Refuse a reservation only when the counter is saturated and no retire frees a slot this cycle.
   // The result ignores iss_valid, so decode can hold its request without a combinational loop.
   always_comb begin
      iss_ready = 1'b1;
      if (iss_rd == ADDR_X0) begin
         iss_ready = 1'b1;
      end else if ((cnt_r[iss_rd] == CNT_MAX) && !(wen && (waddr == iss_rd))) begin
         iss_ready = 1'b0;
      end else begin
         iss_ready = 1'b1;
      end
   end

   assign fire_iss_s = iss_valid && iss_ready;

   // Per-register increment and decrement requests. Retiring an untracked register does not decrement.
   always_comb begin
      inc_s = {NREG{1'b0}};
      dec_s = {NREG{1'b0}};
      for (int i = 1; i < NREG; i++) begin
         inc_s[i] = fire_iss_s && (iss_rd == AW'(i));
         dec_s[i] = wen && (waddr == AW'(i)) && (cnt_r[i] != CNT_ZERO);
      end
   end

   // Next counter values: flush clears everything, and a simultaneous issue and retire cancel out.
   always_comb begin
      cnt_nxt_s[0] = CNT_ZERO;
      for (int i = 1; i < NREG; i++) begin
         if (flush) begin
            cnt_nxt_s[i] = CNT_ZERO;
         end else if (inc_s[i] && dec_s[i]) begin
            cnt_nxt_s[i] = cnt_r[i];
         end else if (inc_s[i]) begin
            cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
         end else if (dec_s[i]) begin
            cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
         end else begin
            cnt_nxt_s[i] = cnt_r[i];
         end
      end
   end

   // State update: reset clears everything; otherwise write back the data and advance the counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_r[i] <= {XLEN{1'b0}};
            cnt_r[i]  <= CNT_ZERO;
         end
      end else begin
         regs_r[0] <= {XLEN{1'b0}};
         cnt_r[0]  <= CNT_ZERO;
         for (int i = 1; i < NREG; i++) begin
            cnt_r[i] <= cnt_nxt_s[i];
            if (wen && (waddr == AW'(i))) begin
               regs_r[i] <= wdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_ysyx_22041461_regfile_sb.sv
// Bench for ysyx_22041461_regfile_sb: behavioural scoreboard model plus directed and random stimulus.
module tb_ysyx_22041461_regfile_sb;

   localparam int XLEN = 64;
   localparam int NREG = 32;
   localparam int AW   = 5;
   localparam int MAXC = 3;

   logic            clk;
   logic            rst;
   logic [AW-1:0]   rs1, rs2, iss_rd, waddr;
   logic [XLEN-1:0] rs1_data, rs2_data, wdata;
   logic            rs1_busy, rs2_busy, iss_valid, iss_ready, wen, flush;

   ysyx_22041461_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .CNTW(2)) dut (
      .clk(clk), .rst(rst),
      .rs1(rs1), .rs2(rs2),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
      .wen(wen), .waddr(waddr), .wdata(wdata),
      .flush(flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   // Model state: architectural values and outstanding-write counts as plain integers.
   logic [XLEN-1:0] m_reg [NREG];
   int              m_cnt [NREG];

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [XLEN-1:0] exp_data(input int a);
      if (a == 0) return 64'd0;
      if (wen && int'(waddr) == a) return wdata;
      return m_reg[a];
   endfunction

   function automatic logic exp_busy(input int a);
      if (a == 0) return 1'b0;
      if (m_cnt[a] == 0) return 1'b0;
      if (wen && int'(waddr) == a && m_cnt[a] == 1) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic exp_ready();
      int r;
      r = int'(iss_rd);
      if (r == 0) return 1'b1;
      if (m_cnt[r] < MAXC) return 1'b1;
      if (wen && int'(waddr) == r) return 1'b1;
      return 1'b0;
   endfunction

   // Compare process: checks every cycle mid-low-phase, then advances the model across the coming edge.
   initial begin
      for (int i = 0; i < NREG; i++) begin
         m_reg[i] = 64'd0;
         m_cnt[i] = 0;
      end
      forever begin
         @(negedge clk);
         #2;
         if (chk_en && !rst) begin
            chk("rs1_data", rs1_data, exp_data(int'(rs1)));
            chk("rs2_data", rs2_data, exp_data(int'(rs2)));
            chk("rs1_busy", {63'd0, rs1_busy}, {63'd0, exp_busy(int'(rs1))});
            chk("rs2_busy", {63'd0, rs2_busy}, {63'd0, exp_busy(int'(rs2))});
            chk("iss_ready", {63'd0, iss_ready}, {63'd0, exp_ready()});
         end
         if (rst) begin
            for (int i = 0; i < NREG; i++) begin
               m_reg[i] = 64'd0;
               m_cnt[i] = 0;
            end
         end else begin
            int  wa, ir;
            bit  inc, dec;
            wa  = int'(waddr);
            ir  = int'(iss_rd);
            inc = iss_valid && exp_ready() && ir != 0;
            dec = wen && wa != 0 && m_cnt[wa] > 0;
            if (wen && wa != 0) m_reg[wa] = wdata;
            if (flush) begin
               for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
            end else begin
               if (inc) m_cnt[ir] = m_cnt[ir] + 1;
               if (dec) m_cnt[wa] = m_cnt[wa] - 1;
            end
         end
      end
   end

   task automatic idle();
      rst = 1'b0; wen = 1'b0; waddr = 5'd0; wdata = 64'd0;
      iss_valid = 1'b0; iss_rd = 5'd0; flush = 1'b0;
      rs1 = 5'd0; rs2 = 5'd0;
   endtask

   // Advance one cycle: inputs set now are held until the next falling edge.
   task automatic nb();
      @(negedge clk);
   endtask

   task automatic issue(input logic [AW-1:0] rd);
      idle(); iss_valid = 1'b1; iss_rd = rd; nb();
   endtask

   task automatic retire(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      idle(); wen = 1'b1; waddr = a; wdata = d; nb();
   endtask

   // Directed scenarios with literal expectations, then random traffic checked by the model.
   initial begin
      idle();
      rst = 1'b1;
      nb();
      chk_en = 1'b1;
      nb();
      idle();

      // Reset clears a written register
      retire(5'd5, 64'h1234);
      idle(); rs1 = 5'd5; #3;
      chk("lit_x5_written", rs1_data, 64'h1234);
      nb();
      idle(); rst = 1'b1; wen = 1'b1; waddr = 5'd5; wdata = 64'h9999; iss_valid = 1'b1; iss_rd = 5'd5; nb();
      idle(); rs1 = 5'd5; iss_rd = 5'd5; #3;
      chk("lit_rst_data", rs1_data, 64'h0);
      chk("lit_rst_busy", {63'd0, rs1_busy}, 64'd0);
      chk("lit_rst_ready", {63'd0, iss_ready}, 64'd1);
      nb();

      // x0 guard
      idle(); wen = 1'b1; waddr = 5'd0; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
      iss_valid = 1'b1; iss_rd = 5'd0; rs1 = 5'd0; #3;
      chk("lit_x0_data", rs1_data, 64'h0);
      chk("lit_x0_busy", {63'd0, rs1_busy}, 64'd0);
      chk("lit_x0_ready", {63'd0, iss_ready}, 64'd1);
      nb();
      idle(); rs1 = 5'd0; rs2 = 5'd0; #3;
      chk("lit_x0_after", rs1_data, 64'h0);
      nb();

      // Bypass and busy
      issue(5'd7);
      idle(); rs2 = 5'd7; #3;
      chk("lit_x7_busy", {63'd0, rs2_busy}, 64'd1);
      nb();
      idle(); rs2 = 5'd7; nb();
      idle(); rs2 = 5'd7; wen = 1'b1; waddr = 5'd7; wdata = 64'hDEAD; #3;
      chk("lit_x7_bypass", rs2_data, 64'hDEAD);
      chk("lit_x7_retire_busy", {63'd0, rs2_busy}, 64'd0);
      nb();
      idle(); rs2 = 5'd7; #3;
      chk("lit_x7_array", rs2_data, 64'hDEAD);
      nb();

      // Saturation
      issue(5'd3); issue(5'd3); issue(5'd3);
      idle(); iss_rd = 5'd3; rs1 = 5'd3; #3;
      chk("lit_sat_ready", {63'd0, iss_ready}, 64'd0);
      chk("lit_sat_busy", {63'd0, rs1_busy}, 64'd1);
      nb();
      idle(); iss_valid = 1'b1; iss_rd = 5'd3; wen = 1'b1; waddr = 5'd3; wdata = 64'h1; #3;
      chk("lit_sat_ready_wen", {63'd0, iss_ready}, 64'd1);
      nb();
      idle(); iss_rd = 5'd3; #3;
      chk("lit_sat_still_full", {63'd0, iss_ready}, 64'd0);
      nb();
      retire(5'd3, 64'h2);
      retire(5'd3, 64'h3);
      idle(); wen = 1'b1; waddr = 5'd3; wdata = 64'h4; rs1 = 5'd3; #3;
      chk("lit_sat_last_retire", {63'd0, rs1_busy}, 64'd0);
      nb();
      idle(); rs1 = 5'd3; #3;
      chk("lit_sat_drained", {63'd0, rs1_busy}, 64'd0);
      nb();

      // Flush
      issue(5'd4); issue(5'd9);
      idle(); flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd4; wen = 1'b1; waddr = 5'd9; wdata = 64'h55; nb();
      idle(); rs1 = 5'd4; rs2 = 5'd9; #3;
      chk("lit_flush_b4", {63'd0, rs1_busy}, 64'd0);
      chk("lit_flush_b9", {63'd0, rs2_busy}, 64'd0);
      chk("lit_flush_d9", rs2_data, 64'h55);
      nb();
      retire(5'd4, 64'hAB);
      idle(); rs1 = 5'd4; #3;
      chk("lit_late_data", rs1_data, 64'hAB);
      chk("lit_late_busy", {63'd0, rs1_busy}, 64'd0);
      nb();

      // Random issue/retire/flush traffic on a small register window to provoke hazards
      for (int n = 0; n < 600; n++) begin
         idle();
         rst       = ($urandom_range(0, 99) == 0);
         flush     = ($urandom_range(0, 19) == 0);
         wen       = $urandom_range(0, 1);
         waddr     = AW'($urandom_range(0, 7));
         wdata     = {$urandom, $urandom};
         iss_valid = ($urandom_range(0, 2) != 0);
         iss_rd    = AW'($urandom_range(0, 7));
         rs1       = AW'($urandom_range(0, 7));
         rs2       = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : waddr;
         nb();
      end

      idle();
      nb();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
